alu_mdu: RTL
============

# alu_mdu

Parametrised execute unit: the RV32I/RV64I integer ALU operations plus the RV M-extension multiply/divide, behind a valid/ready handshake on both sides. Simple operations complete in one cycle. Multiply and divide run iteratively (one bit per cycle) with fast paths for the divide corner cases. It sits in the EX stage between decode/operand fetch and writeback, and stalls decode through `in_ready` while an iterative operation is in flight.

## Interface
Parameters:
- `XLEN`, 32: datapath width; power of two, ≥ 8.
- `SHW`, `$clog2(XLEN)`: shift-amount width; derived, never overridden.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous abort of any in-flight or pending result.
- `in_valid` input 1: operation request.
- `in_ready` output 1: unit can accept; equals `state==IDLE && !rst`.
- `op` input 5: operation code.
- `src1` input XLEN: operand 1.
- `src2` input XLEN: operand 2.
- `out_valid` output 1: `result` is valid.
- `out_ready` input 1: consumer accepts the result.
- `result` output XLEN: registered result.

## Operation
- Op codes, all arithmetic modulo 2^XLEN:
  - 0 add; 1 slt (signed compare); 2 sltu; 3 xor; 4 or; 5 and.
  - 6 sll; 7 srl; 8 sra. Shift amount is `src2[SHW-1:0]`.
  - 9 sub.
  - 10 mul (low XLEN bits); 11 mulh (s×s); 12 mulhsu (s×u); 13 mulhu (u×u); 14 div; 15 divu; 16 rem; 17 remu.
  - 18–31: illegal; result 0 with single-cycle latency.
- Accept occurs when `in_valid && in_ready`. Operands and op are latched on accept.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → DONE on accept of ops 0–9, illegal ops, or a divide fast path. `result` is written on that edge.
  - IDLE → BUSY on accept of ops 10–17 without a fast path. An iteration counter is loaded with XLEN.
  - BUSY: one shift-add step (multiply) or one restoring-subtract step (divide) per cycle. The counter decrements each step. At counter==1 the final step writes `result` and the state moves to DONE.
  - DONE: `out_valid`=1. On `out_ready` the state moves to IDLE. A new request cannot be accepted in the same cycle (no bypass).
- Signed multiply/divide: operands are converted to magnitude plus sign. The iteration runs unsigned on a 2·XLEN product or on a quotient/remainder pair. The sign is fixed on the final step: product sign = s1^s2; quotient sign = s1^s2; remainder takes the sign of the dividend.
- Divide fast paths, each taking one cycle to DONE:
  - Divisor 0: div/divu = all ones; rem/remu = src1.
  - Signed overflow (src1 = −2^(XLEN−1), src2 = −1): div = src1; rem = 0.
- `flush` (when `rst`=0) forces IDLE and clears `out_valid` on the next edge. Any accept presented in the same cycle is discarded.
- `rst` has priority over `flush`. A reset in any state, including mid-iteration, returns to IDLE with no residual result.

## Timing
- Reset values: state IDLE, `out_valid`=0, `result`=0, counter 0. `in_ready` is 0 while `rst`=1 and 1 on the first cycle after.
- Accept at edge N: ops 0–9, illegal ops, and fast paths give `out_valid`=1 from cycle N+1.
- Iterative mul/div: `out_valid`=1 from cycle N+XLEN+1, i.e. 33 cycles after accept for XLEN=32.
- `result` and `out_valid` are held stable while `out_valid && !out_ready`.
- `in_ready`=0 in BUSY and DONE. Peak throughput is one op per 2 cycles for simple ops.
- `in_valid` and operands are ignored unless `in_ready`=1. The source must hold them until accepted.

## Test plan
- Reset then simple ops (XLEN=32):
  - add 0xFFFFFFFF+1 → 0.
  - slt −1,1 → 1; sltu −1,1 → 0.
  - sra 0x80000000 by 0x21 → 0xC0000000 (shift amount masked to 1).
  - Each result at N+1.
- Multiply family with src1=0xFFFFFFFF, src2=2:
  - mul → 0xFFFFFFFE; mulh → 0xFFFFFFFF; mulhsu → 0xFFFFFFFF; mulhu → 0x00000001.
  - `out_valid` exactly 33 cycles after accept; `in_ready`=0 throughout.
- Divide family:
  - div −7,2 → 0xFFFFFFFD; rem −7,2 → 0xFFFFFFFF; divu 100,7 → 14; remu 100,7 → 2.
  - div 5,0 → 0xFFFFFFFF; rem 5,0 → 5; div 0x80000000,−1 → 0x80000000, rem 0.
  - Fast paths done at N+1.
- Backpressure: hold `out_ready`=0 for 10 cycles after a mul completes → `result` stable, `out_valid`=1, `in_ready`=0; on release the next request is accepted one cycle later.
- `rst` at iteration 15 of a div → `out_valid`=0, `result`=0. A following add 3+4 → 7 at N+1.
- `flush` in DONE with `out_ready`=0 → `out_valid` drops next cycle, result never consumed. A request in the flush cycle is not accepted.

Source files
------------

// File: rtl/alu_mdu_if.sv
// Request/response bundle between the operand-fetch stage, the alu_mdu and writeback.
interface alu_mdu_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, src1, src2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, src1, src2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/alu_mdu.sv
// RV ALU + M-extension execute unit: simple ops ready 1 cycle after accept, mul/div XLEN+1.
// No new accept while a result is pending; result/out_valid held until out_ready.
module alu_mdu #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  alu_mdu_if.slave  bus
);

  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [XLEN-1:0]     opd_q, opd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [4:0]          op_q, op_d;
  logic                neg_q, neg_d;

  logic [4:0]          op;
  logic [XLEN-1:0]     src1, src2;
  logic                accept;

  assign op   = bus.op;
  assign src1 = bus.src1;
  assign src2 = bus.src2;

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign accept        = bus.in_valid && bus.in_ready && !flush;

  // ---------------- single-cycle operations ----------------
  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] simple_res;

  assign sh = src2[SHW-1:0];

  always_comb begin
    simple_res = '0;
    case (op)
      5'd0: simple_res = src1 + src2;
      5'd1: simple_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      5'd2: simple_res = {{(XLEN-1){1'b0}}, src1 < src2};
      5'd3: simple_res = src1 ^ src2;
      5'd4: simple_res = src1 | src2;
      5'd5: simple_res = src1 & src2;
      5'd6: simple_res = src1 << sh;
      5'd7: simple_res = src1 >> sh;
      5'd8: simple_res = $signed(src1) >>> sh;
      5'd9: simple_res = src1 - src2;
      default: simple_res = '0;
    endcase
  end

  // ---------------- operand conditioning for mul/div ----------------
  logic            is_mul, is_div, is_rem, is_simple;
  logic            sgn1, sgn2, s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    is_mul    = (op >= 5'd10) && (op <= 5'd13);
    is_div    = (op >= 5'd14) && (op <= 5'd17);
    is_rem    = (op == 5'd16) || (op == 5'd17);
    is_simple = !is_mul && !is_div;
    sgn1      = (op == 5'd10) || (op == 5'd11) || (op == 5'd12) ||
                (op == 5'd14) || (op == 5'd16);
    sgn2      = (op == 5'd10) || (op == 5'd11) || (op == 5'd14) || (op == 5'd16);
    s1        = sgn1 && src1[XLEN-1];
    s2        = sgn2 && src2[XLEN-1];
    mag1      = s1 ? -src1 : src1;
    mag2      = s2 ? -src2 : src2;
    div_zero  = is_div && (src2 == '0);
    div_ovf   = ((op == 5'd14) || (op == 5'd16)) &&
                (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    fast_res  = '0;
    if (div_zero)
      fast_res = is_rem ? src1 : '1;
    else if (div_ovf)
      fast_res = is_rem ? '0 : src1;
  end

  // ---------------- iterative step ----------------
  // acc holds {product_hi, multiplier} for mul and {remainder, dividend} for div.
  logic              step_is_mul;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] step_next, prod_fix;
  logic [XLEN-1:0]   quo, rem, final_res;

  always_comb begin
    step_is_mul = (op_q <= 5'd13);
    mul_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    div_shift   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff    = div_shift - {1'b0, opd_q};
    div_ge      = !div_diff[XLEN];
    div_rem     = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    if (step_is_mul)
      step_next = {mul_sum, acc_q[XLEN-1:1]};
    else
      step_next = {div_rem, acc_q[XLEN-2:0], div_ge};

    prod_fix  = neg_q ? -step_next : step_next;
    quo       = step_next[XLEN-1:0];
    rem       = step_next[2*XLEN-1:XLEN];
    final_res = '0;
    case (op_q)
      5'd10:        final_res = prod_fix[XLEN-1:0];
      5'd11, 5'd12,
      5'd13:        final_res = prod_fix[2*XLEN-1:XLEN];
      5'd14, 5'd15: final_res = neg_q ? -quo : quo;
      5'd16, 5'd17: final_res = neg_q ? -rem : rem;
      default:      final_res = '0;
    endcase
  end

  // ---------------- next-state ----------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    opd_d    = opd_q;
    acc_d    = acc_q;
    op_d     = op_q;
    neg_d    = neg_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = op;
          if (is_simple) begin
            result_d = simple_res;
            state_d  = DONE;
          end else if (div_zero || div_ovf) begin
            result_d = fast_res;
            state_d  = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(XLEN);
            if (is_mul) begin
              acc_d = {{XLEN{1'b0}}, mag2};
              opd_d = mag1;
              neg_d = s1 ^ s2;
            end else begin
              acc_d = {{XLEN{1'b0}}, mag1};
              opd_d = mag2;
              neg_d = is_rem ? s1 : (s1 ^ s2);
            end
          end
        end
      end
      BUSY: begin
        acc_d = step_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          result_d = final_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      opd_q    <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      opd_q    <= opd_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
    end
  end

endmodule
